// File: rtl/std_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : std_div_iter                                                  |
// | Purpose  : Iterative restoring divider with a go/done handshake.         |
// |            It produces the quotient and the remainder together and       |
// |            resolves steps_per_cycle quotient bits on each clock. In      |
// |            signed mode it divides two's-complement operands and          |
// |            truncates toward zero. Every operand pair, including a zero   |
// |            divisor, takes the same number of cycles.                     |
// | Ports    : clk           - clock                                         |
// |            reset         - asynchronous, active-high reset               |
// |            go            - start/hold request; dropping it aborts        |
// |            left, right   - dividend and divisor, sampled at start only   |
// |            out_quotient  - registered quotient, held until next result   |
// |            out_remainder - registered remainder, held until next result  |
// |            done          - one-cycle completion pulse                    |
// |            div_by_zero   - registered flag, set with done when right==0  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module std_div_iter #(
  parameter int width           = 32,
  parameter int steps_per_cycle = 1,
  parameter int signed_mode     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done,
  output logic             div_by_zero
);

  localparam int STEPS = width / steps_per_cycle;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Dividend bits leave the top of dq while quotient bits enter at the bottom,
  // so after all steps dq holds the quotient magnitude.
  logic [width-1:0] dq;
  // One extra bit keeps the shifted partial remainder from overflowing before
  // it is compared against the divisor.
  logic [width:0]   rem;
  logic [width-1:0] dvs;
  logic [width-1:0] left_cap;
  logic             zero_div;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] count;

  logic             left_neg;
  logic             right_neg;
  logic [width-1:0] left_mag;
  logic [width-1:0] right_mag;
  logic [width-1:0] dq_step;
  logic [width:0]   rem_step;
  logic [width-1:0] q_fix;
  logic [width-1:0] r_fix;

  generate
    if (signed_mode != 0) begin : g_signed
      assign left_neg  = left[width-1];
      assign right_neg = right[width-1];
    end else begin : g_unsigned
      assign left_neg  = 1'b0;
      assign right_neg = 1'b0;
    end
  endgenerate

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(width-1).
  assign left_mag  = left_neg  ? -left  : left;
  assign right_mag = right_neg ? -right : right;

  // steps_per_cycle restoring-division steps chained combinationally.
  always_comb begin
    rem_step = rem;
    dq_step  = dq;
    for (int s = 0; s < steps_per_cycle; s++) begin
      rem_step = {rem_step[width-1:0], dq_step[width-1]};
      dq_step  = {dq_step[width-2:0], 1'b0};
      if (rem_step >= {1'b0, dvs}) begin
        rem_step   = rem_step - {1'b0, dvs};
        dq_step[0] = 1'b1;
      end
    end
  end

  // Sign correction, bypassed for a zero divisor so the raw dividend and an
  // all-ones quotient are reported unchanged.
  always_comb begin
    q_fix = neg_q ? -dq : dq;
    r_fix = neg_r ? -rem[width-1:0] : rem[width-1:0];
    if (zero_div) begin
      q_fix = '1;
      r_fix = left_cap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!go) begin
          state_next = S_IDLE;
        end else if (count == CNT_W'(1)) begin
          state_next = S_FIN;
        end
      end
      S_FIN:   state_next = go ? S_DONE : S_IDLE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq            <= '0;
      rem           <= '0;
      dvs           <= '0;
      left_cap      <= '0;
      zero_div      <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      count         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            dq       <= left_mag;
            rem      <= '0;
            dvs      <= right_mag;
            left_cap <= left;
            zero_div <= (right == '0);
            neg_q    <= left_neg ^ right_neg;
            neg_r    <= left_neg;
            count    <= CNT_W'(STEPS);
          end
        end
        S_RUN: begin
          if (go) begin
            dq    <= dq_step;
            rem   <= rem_step;
            count <= count - CNT_W'(1);
          end
        end
        S_FIN: begin
          if (go) begin
            out_quotient  <= q_fix;
            out_remainder <= r_fix;
            div_by_zero   <= zero_div;
            done          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_std_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_std_div_iter                                               |
// | Purpose  : Self-checking bench for std_div_iter. Three 8-bit builds:     |
// |            [0] unsigned, 1 bit/clk; [1] unsigned, 4 bits/clk;            |
// |            [2] signed, 2 bits/clk. Results come from plain arithmetic.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_std_div_iter;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      go;
  logic [2:0][7:0] left;
  logic [2:0][7:0] right;
  wire  [2:0][7:0] q;
  wire  [2:0][7:0] r;
  wire  [2:0]      done;
  wire  [2:0]      dz;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] last_q [3];
  logic [7:0] last_r [3];
  logic       last_dz [3];

  always #5 clk = ~clk;

  std_div_iter #(.width(8), .steps_per_cycle(1), .signed_mode(0)) u_u1 (
    .clk(clk), .reset(reset), .go(go[0]), .left(left[0]), .right(right[0]),
    .out_quotient(q[0]), .out_remainder(r[0]), .done(done[0]), .div_by_zero(dz[0]));

  std_div_iter #(.width(8), .steps_per_cycle(4), .signed_mode(0)) u_u4 (
    .clk(clk), .reset(reset), .go(go[1]), .left(left[1]), .right(right[1]),
    .out_quotient(q[1]), .out_remainder(r[1]), .done(done[1]), .div_by_zero(dz[1]));

  std_div_iter #(.width(8), .steps_per_cycle(2), .signed_mode(1)) u_s2 (
    .clk(clk), .reset(reset), .go(go[2]), .left(left[2]), .right(right[2]),
    .out_quotient(q[2]), .out_remainder(r[2]), .done(done[2]), .div_by_zero(dz[2]));

  function automatic int n_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 4;
  endfunction

  // Reference: C-style truncating division, zero divisor gives all ones / dividend.
  function automatic void model(input int k, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] eq, output logic [7:0] er,
                                output logic edz);
    int sa;
    int sb;
    int qi;
    int ri;
    if (b == 8'd0) begin
      eq  = 8'hFF;
      er  = a;
      edz = 1'b1;
    end else if (k == 2) begin
      sa  = $signed(a);
      sb  = $signed(b);
      qi  = sa / sb;
      ri  = sa % sb;
      eq  = qi[7:0];
      er  = ri[7:0];
      edz = 1'b0;
    end else begin
      eq  = a / b;
      er  = a % b;
      edz = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_held(input int k, input string tag);
    check({tag, "_q"},    32'(q[k]),    32'(last_q[k]));
    check({tag, "_r"},    32'(r[k]),    32'(last_r[k]));
    check({tag, "_dz"},   32'(dz[k]),   32'(last_dz[k]));
    check({tag, "_done"}, 32'(done[k]), 32'd0);
  endtask

  // Full operation: checks latency, held outputs before FIN, result, single pulse.
  task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    int         seen;
    model(k, a, b, eq, er, edz);
    @(negedge clk);
    go[k] = 1'b1; left[k] = a; right[k] = b;
    @(posedge clk); #1;
    left[k]  = 8'($urandom);
    right[k] = 8'($urandom);
    seen = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done[k]) begin
        seen = e;
        break;
      end
      if (e == n_of(k)) check_held(k, {tag, "_hold"});
    end
    check({tag, "_latency"}, 32'(seen), 32'(n_of(k) + 1));
    check({tag, "_q"},  32'(q[k]),  32'(eq));
    check({tag, "_r"},  32'(r[k]),  32'(er));
    check({tag, "_dz"}, 32'(dz[k]), 32'(edz));
    go[k] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(done[k]), 32'd0);
    last_q[k] = eq; last_r[k] = er; last_dz[k] = edz;
  endtask

  // Start, then drop go just before edge drop_edge; no pulse, outputs retained.
  task automatic do_abort(input int k, input logic [7:0] a, input logic [7:0] b,
                          input int drop_edge, input string tag);
    int pulses;
    @(negedge clk);
    go[k] = 1'b1; left[k] = a; right[k] = b;
    @(posedge clk);
    repeat (drop_edge - 1) @(posedge clk);
    #1;
    go[k] = 1'b0;
    pulses = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (done[k]) pulses++;
    end
    check({tag, "_pulses"}, 32'(pulses), 32'd0);
    check_held(k, tag);
  endtask

  initial begin
    logic [7:0] e1q, e1r, e2q, e2r, a, b, ce;
    logic       e1z, e2z, cz;
    int         pulses;
    int         k;

    reset = 1'b1;
    go    = '0;
    left  = '0;
    right = '0;
    for (int i = 0; i < 3; i++) begin
      last_q[i] = 8'd0; last_r[i] = 8'd0; last_dz[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_held(i, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    do_op(0, 8'd200, 8'd7,  "t1_200_7");
    do_op(1, 8'd255, 8'd16, "t2_255_16");
    do_op(1, 8'd5,   8'd9,  "t2_5_9");
    do_op(0, 8'd93,  8'd0,  "t3u_div0");
    do_op(0, 8'd9,   8'd3,  "t3u_9_3");
    do_op(2, 8'd93,  8'd0,  "t3s_div0");
    do_op(2, 8'd9,   8'd3,  "t3s_9_3");
    do_op(2, 8'hF9,  8'd2,  "t4_m7_2");
    do_op(2, 8'd7,   8'hFE, "t4_7_m2");
    do_op(2, 8'h80,  8'hFF, "t4_min_m1");
    do_op(1, 8'd0,   8'd13, "zero_dividend");

    do_op(0, 8'd200, 8'd7, "t5_pre");
    do_abort(0, 8'd17, 8'd3, 4, "t5_abort_run");
    do_abort(1, 8'd17, 8'd3, 3, "abort_fin");
    do_op(0, 8'd100, 8'd10, "t5_restart");

    // Reset in the middle of a run clears everything without a clock edge.
    @(negedge clk);
    go[0] = 1'b1; left[0] = 8'd200; right[0] = 8'd7;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      last_q[i] = 8'd0; last_r[i] = 8'd0; last_dz[i] = 1'b0;
      check_held(i, "async_reset");
    end
    go[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done != 3'b000) pulses++;
    end
    check("post_reset_pulses", 32'(pulses), 32'd0);
    do_op(0, 8'd9, 8'd3, "post_reset_op");

    // Back-to-back with go held: second start is two edges after the first done.
    model(0, 8'd200, 8'd7, e1q, e1r, e1z);
    model(0, 8'd50,  8'd6, e2q, e2r, e2z);
    @(negedge clk);
    go[0] = 1'b1; left[0] = 8'd200; right[0] = 8'd7;
    @(posedge clk); #1;
    left[0] = 8'd50; right[0] = 8'd6;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      check("b2b_done", 32'(done[0]), 32'((e == 9) || (e == 20)));
      ce = (e >= 20) ? e2q : (e >= 9) ? e1q : last_q[0];
      check("b2b_q", 32'(q[0]), 32'(ce));
      ce = (e >= 20) ? e2r : (e >= 9) ? e1r : last_r[0];
      check("b2b_r", 32'(r[0]), 32'(ce));
      if (e == 20) go[0] = 1'b0;
    end
    last_q[0] = e2q; last_r[0] = e2r; last_dz[0] = e2z;

    // Random operands on all three builds, with occasional zero divisors.
    for (int i = 0; i < 36; i++) begin
      k = i % 3;
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      if (k == 2 && $urandom_range(0, 9) == 0) begin
        a = 8'h80; b = 8'hFF;
      end
      do_op(k, a, b, "rand");
    end

    cz = dz[0];
    check("final_dz_held", 32'(cz), 32'(last_dz[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
